fifo_frame_reader: RTL and testbench

Read-side consumer for the dual-clock FIFO, in the FFT clock domain. Pops words from the FIFO read port, absorbs its one-cycle read latency in a small output buffer, and presents a valid/ready stream framed into FRAME_LEN-sample frames with a last marker. Feeds the FFT input stage. Sustains one word per cycle while the FIFO is non-empty and the sink is ready.

---
 rtl/fifo_frame_reader_pkg.sv | 26 ++
 rtl/fifo_frame_reader_sync_fifo_small.sv | 57 +++++
 rtl/fifo_frame_reader.sv | 117 +++++++++++
 tb/tb_fifo_frame_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_reader_pkg.sv
// Shared types and constants for the FIFO frame reader.
// Optional underrun counter: FIFO_FRAME_READER_UNDERRUN_CNT_EN.
package fifo_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int OUT_BUF_DEPTH  = 4;
  localparam int OUT_PTR_W      = $clog2(OUT_BUF_DEPTH);
  localparam int OUT_CNT_W      = $clog2(OUT_BUF_DEPTH + 1);
  localparam int UNDERRUN_CNT_W = 16;

  // Room for one more pop: buffered words plus the one in flight.
  function automatic logic buf_has_room(
    input logic [OUT_CNT_W-1:0] cnt,
    input logic                 inflight
  );
    logic [OUT_CNT_W:0] w_sum;
    w_sum = {1'b0, cnt} + {{OUT_CNT_W{1'b0}}, inflight};
    return w_sum < (OUT_CNT_W+1)'(OUT_BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_frame_reader_sync_fifo_small.sv
// Small single-clock output buffer absorbing the FIFO read latency.
// Build option (top level): FIFO_FRAME_READER_UNDERRUN_CNT_EN.
module sync_fifo_small
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [OUT_CNT_W-1:0]  o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_mem [OUT_BUF_DEPTH];
  logic [OUT_PTR_W-1:0]  r_rd_ptr;
  logic [OUT_PTR_W-1:0]  r_wr_ptr;
  logic [OUT_CNT_W-1:0]  r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == OUT_CNT_W'(OUT_BUF_DEPTH));
  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_frame_reader.sv
// FFT-domain FIFO consumer framing words into FRAME_LEN-sample frames.
// Optional underrun counter: FIFO_FRAME_READER_UNDERRUN_CNT_EN.
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  input  logic                      fifo_rd_empty,
  input  logic                      frame_enable,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_last,
  output logic                      busy
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic                 r_inflight;
  logic [IDX_W-1:0]     r_issue_idx;
  logic [IDX_W-1:0]     r_out_idx;
  logic [OUT_CNT_W-1:0] w_count;
  logic                 w_room;
  logic                 w_rd_en;
  logic                 w_issue_wrap;
  logic                 w_hs;

  sync_fifo_small #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_push_data(fifo_rd_data),
    .i_pop      (w_hs),
    .o_count    (w_count),
    .o_head     (m_data)
  );

  // Credit check ignores a same-cycle output pop, keeping m_ready off this path.
  assign w_room       = buf_has_room(w_count, r_inflight);
  assign w_rd_en      = (r_state == ST_RUN) & ~fifo_rd_empty & w_room;
  assign w_issue_wrap = w_rd_en & (r_issue_idx == LAST_IDX);
  assign w_hs         = m_valid & m_ready;

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = (w_count != '0);
  assign m_last     = m_valid & (r_out_idx == LAST_IDX);
  assign busy       = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (frame_enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_issue_wrap && !frame_enable) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((w_count == '0) && !r_inflight) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_inflight  <= 1'b0;
      r_issue_idx <= '0;
      r_out_idx   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_issue_idx <= w_issue_wrap ? '0 : r_issue_idx + 1'b1;
      end
      if (w_hs) begin
        r_out_idx <= (r_out_idx == LAST_IDX) ? '0 : r_out_idx + 1'b1;
      end
    end
  end

`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] r_underrun;
  logic                      w_starve;

  // Waiting for the first word of a frame is not starvation.
  assign w_starve = (r_state == ST_RUN) & fifo_rd_empty & w_room &
                    ((r_issue_idx != '0) | (r_out_idx != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= '0;
    end else if (w_starve && (r_underrun != '1)) begin
      r_underrun <= r_underrun + 1'b1;
    end
  end

  assign underrun_cnt = r_underrun;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Randomized self-checking bench for fifo_frame_reader.
// Underrun scenario runs when FIFO_FRAME_READER_UNDERRUN_CNT_EN is defined.
module tb_fifo_frame_reader;

  localparam int DW = 8;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic          frame_enable = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  always #5 clk = ~clk;

  fifo_frame_reader #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .frame_enable (frame_enable),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy)
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  // Source FIFO model: stimulus appends, the pop process consumes.
  logic [DW-1:0] src_mem [256];
  int            src_wr = 0;
  int            src_rd = 0;
  logic          flush_req = 1'b0;

  assign fifo_rd_empty = (src_rd == src_wr);

  always @(posedge clk) begin
    if (flush_req) begin
      src_rd <= src_wr;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= src_mem[src_rd];
      src_rd       <= src_rd + 1;
    end
  end

  int            n_chk = 0;
  int            n_err = 0;
  int            out_ptr = 0;
  int            n_out = 0;
  int            n_last = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected stream: source words in pop order, framed every FL outputs.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_ptr = src_rd;
        n_out   = 0;
        n_last  = 0;
        stall_q = 1'b0;
      end else begin
        chk("credit", 32'((src_rd - out_ptr) <= 4), 1);
        chk("rd_en_empty", fifo_rd_en & fifo_rd_empty, 0);
        if (!m_valid) chk("last_no_valid", m_last, 0);
        if (stall_q) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, hold_d);
          chk("stall_last", m_last, hold_l);
        end
        if (m_valid && m_ready) begin
          if (out_ptr == src_rd) begin
            chk("spurious", m_valid, 0);
          end else begin
            chk("data", m_data, src_mem[out_ptr]);
          end
          chk("last", m_last, 32'((n_out % FL) == FL - 1));
          if (m_last) n_last++;
          out_ptr++;
          n_out++;
        end
        stall_q = m_valid & ~m_ready;
        hold_d  = m_data;
        hold_l  = m_last;
      end
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    src_mem[src_wr] = v;
    src_wr          = src_wr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    frame_enable = 1'b0;
    m_ready      = 1'b0;
    flush_req    = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int c = 0;
    while (n_out < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(n_out >= n), 1);
  endtask

  initial begin
    int c;
    int b;
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    fork
      monitor();
    join_none

    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_data", m_data, 0);
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
    chk("rst_underrun", underrun_cnt, 0);
`endif

    // Frame and latency
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
    m_ready      = 1'b1;
    frame_enable = 1'b1;
    @(negedge clk);
    chk("lat_rd_en_pre", fifo_rd_en, 0);
    @(negedge clk);
    chk("lat_rd_en", fifo_rd_en, 1);
    @(negedge clk);
    chk("lat_valid_e1", m_valid, 0);
    @(negedge clk);
    chk("lat_valid_e2", m_valid, 1);
    chk("lat_first", m_data, 8'h10);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("lat_stream", m_valid, 1);
    end
    #1;
    wait_out(8, 20, "lat_count");
    chk("lat_lasts", n_last, 2);

    // Backpressure
    do_reset();
    for (int i = 0; i < 16; i++) push(DW'($urandom));
    frame_enable = 1'b1;
    c = 0;
    while (n_out < 16 && c < 600) begin
      m_ready = (c < 6) ? pat[c][0] : 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    chk("bp_count", n_out, 16);
    chk("bp_lasts", n_last, 4);
    chk("bp_drained", src_wr - src_rd, 0);

    // Stop during frame 2
    do_reset();
    b = src_rd;
    for (int i = 0; i < 12; i++) push(DW'($urandom));
    frame_enable = 1'b1;
    c = 0;
    while ((src_rd - b) < 5 && c < 200) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    chk("stop_reach", 32'((src_rd - b) >= 5), 1);
    frame_enable = 1'b0;
    c = 0;
    while (n_out < 8 && c < 400) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    chk("stop_count", n_out, 8);
    @(posedge clk);
    @(negedge clk);
    chk("stop_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stop_no_rd", fifo_rd_en, 0);
    end
    chk("stop_pops", src_rd - b, 8);
    chk("stop_lasts", n_last, 2);

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 8; i++) push(DW'(8'h20 + i));
    m_ready      = 1'b1;
    frame_enable = 1'b1;
    wait_out(2, 20, "mr_two");
    rst_n = 1'b0;
    #1;
    chk("mr_valid", m_valid, 0);
    chk("mr_rd_en", fifo_rd_en, 0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_out(4, 30, "mr_after");
    chk("mr_lasts", n_last, 1);

    // Idle with empty FIFO
    do_reset();
    frame_enable = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ie_rd_en", fifo_rd_en, 0);
      chk("ie_busy", busy, 1);
`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
      chk("ie_underrun", underrun_cnt, 0);
`endif
    end
    frame_enable = 1'b0;

`ifdef FIFO_FRAME_READER_UNDERRUN_CNT_EN
    // Mid-frame starvation of exactly five cycles
    do_reset();
    push(8'h30);
    push(8'h31);
    m_ready      = 1'b1;
    frame_enable = 1'b1;
    tick();
    frame_enable = 1'b0;
    c = 0;
    while (!fifo_rd_empty && c < 20) begin
      tick();
      c++;
    end
    chk("ur_empty", fifo_rd_empty, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ur_gap_valid", m_valid, 0);
    tick();
    push(8'h32);
    push(8'h33);
    wait_out(4, 30, "ur_count");
    c = 0;
    while (busy && c < 20) begin
      tick();
      c++;
    end
    chk("ur_idle", busy, 0);
    chk("ur_cnt", underrun_cnt, 5);
    chk("ur_lasts", n_last, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
